// File: rtl/ebus_pkg.sv
// Shared EBUS definitions: data type, driver slot numbering, default slot
// count and the contention-tracking state encoding.
package ebus_pkg;

    // EBUS data word, PDP-10 bit order (bit 0 is the MSB).
    typedef bit [0:35] ebus_data_t;

    localparam int EBUS_NDRV_DEFAULT = 16;

    // Driver slot assignment; a lower index means higher priority on the bus.
    typedef enum logic [3:0] {
        SLOT_APR   = 4'd0,
        SLOT_CON   = 4'd1,
        SLOT_CRA   = 4'd2,
        SLOT_CTL   = 4'd3,
        SLOT_EDP   = 4'd4,
        SLOT_IR    = 4'd5,
        SLOT_MBZ   = 4'd6,
        SLOT_MTR   = 4'd7,
        SLOT_PIC   = 4'd8,
        SLOT_SCD   = 4'd9,
        SLOT_SHM   = 4'd10,
        SLOT_VMA   = 4'd11,
        SLOT_TB    = 4'd12,
        SLOT_RH20  = 4'd13,
        SLOT_DTE20 = 4'd14,
        SLOT_SPARE = 4'd15
    } ebus_slot_t;

    // Contention diagnostic state.
    typedef enum logic {
        ERR_OK      = 1'b0,
        ERR_CONTEND = 1'b1
    } ebus_err_t;

endpackage

// File: rtl/ebus_prio_enc.sv
// Combinational priority encoder for EBUS driver requests.
//   req   in  N        request vector
//   any   out 1        at least one request set
//   idx   out IDX_W    lowest set index (0 when none)
//   multi out 1        more than one request set
module ebus_prio_enc #(
    parameter int N     = 16,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    output logic             any,
    output logic [IDX_W-1:0] idx,
    output logic             multi
);

    logic found;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any   = |req;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(req & (req - 1'b1));

endmodule

// File: rtl/ebus_driver_arb.sv
// EBUS source mux/arbiter. The lowest-index enabled driving slot owns the bus;
// contention and stuck-driver conditions are latched as sticky diagnostics.
//   clk             in   system clock
//   CROBAR          in   synchronous active-high reset
//   drvDriving      in   per-slot drive request
//   drvData         in   per-slot data, slot i at [i*W +: W]
//   drvMask         in   per-slot enable
//   errClear        in   clears sticky diagnostics
//   busData         out  selected bus data
//   busDriving      out  some enabled slot is driving
//   busSrc          out  winning slot index
//   contention      out  sticky multi-driver flag
//   contentionMask  out  request vector at first contention
//   contentionCount out  saturating contention cycle count
//   stuck           out  sticky stuck-driver flag
//   stuckSrc        out  slot that was flagged stuck
module ebus_driver_arb
    import ebus_pkg::*;
#(
    parameter int NDRV      = EBUS_NDRV_DEFAULT,
    parameter int W         = 36,
    parameter int REGOUT    = 1,
    parameter int HOLD_LAST = 0,
    parameter int MAXHOLD   = 64,
    parameter int CNT_W     = 8
) (
    input  logic                    clk,
    input  logic                    CROBAR,
    input  logic [NDRV-1:0]         drvDriving,
    input  logic [0:NDRV*W-1]       drvData,
    input  logic [NDRV-1:0]         drvMask,
    input  logic                    errClear,
    output logic [0:W-1]            busData,
    output logic                    busDriving,
    output logic [$clog2(NDRV)-1:0] busSrc,
    output logic                    contention,
    output logic [NDRV-1:0]         contentionMask,
    output logic [CNT_W-1:0]        contentionCount,
    output logic                    stuck,
    output logic [$clog2(NDRV)-1:0] stuckSrc
);

    localparam int SRC_W = $clog2(NDRV);
    localparam int RUN_W = $clog2(MAXHOLD + 2);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAXHOLD + 1);

    logic [NDRV-1:0]  req;
    logic             any;
    logic             multi;
    logic [SRC_W-1:0] win;
    logic [0:W-1]     sel_data;
    logic [0:W-1]     nxt_data;
    logic [0:W-1]     hold_q;

    ebus_err_t        err_state;
    logic [RUN_W-1:0] run_q;
    logic [RUN_W-1:0] run_base;
    logic [RUN_W-1:0] run_nxt;
    logic [SRC_W-1:0] prev_win;

    assign req = drvDriving & drvMask;

    ebus_prio_enc #(
        .N     (NDRV),
        .IDX_W (SRC_W)
    ) u_prio (
        .req   (req),
        .any   (any),
        .idx   (win),
        .multi (multi)
    );

    assign sel_data = drvData[int'(win)*W +: W];
    assign nxt_data = any ? sel_data : ((HOLD_LAST != 0) ? hold_q : '0);

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            hold_q <= '0;
        end else if (any) begin
            hold_q <= sel_data;
        end
    end

    if (REGOUT != 0) begin : g_regout
        always_ff @(posedge clk) begin
            if (CROBAR) begin
                busData    <= '0;
                busDriving <= 1'b0;
                busSrc     <= '0;
            end else begin
                busData    <= nxt_data;
                busDriving <= any;
                busSrc     <= any ? win : '0;
            end
        end
    end else begin : g_combout
        assign busData    = nxt_data;
        assign busDriving = any;
        assign busSrc     = any ? win : '0;
    end

    // Contention tracking. errClear is applied first, so a contention in the
    // same cycle is captured against the freshly cleared state.
    always_ff @(posedge clk) begin
        if (CROBAR) begin
            err_state       <= ERR_OK;
            contentionMask  <= '0;
            contentionCount <= '0;
        end else if (multi) begin
            if (errClear) begin
                contentionCount <= CNT_W'(1);
            end else if (contentionCount != '1) begin
                contentionCount <= contentionCount + 1'b1;
            end
            if (errClear || err_state == ERR_OK) begin
                err_state      <= ERR_CONTEND;
                contentionMask <= req;
            end
        end else if (errClear) begin
            err_state       <= ERR_OK;
            contentionMask  <= '0;
            contentionCount <= '0;
        end
    end

    assign contention = (err_state == ERR_CONTEND);

    // Run length of the current winner, with errClear zeroing it before this
    // cycle is counted.
    always_comb begin
        run_base = errClear ? '0 : run_q;
        run_nxt  = '0;
        if (any) begin
            if (run_base != '0 && win == prev_win) begin
                run_nxt = (run_base == RUN_LIMIT) ? run_base : run_base + 1'b1;
            end else begin
                run_nxt = RUN_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CROBAR) begin
            run_q    <= '0;
            prev_win <= '0;
            stuck    <= 1'b0;
            stuckSrc <= '0;
        end else begin
            run_q    <= run_nxt;
            prev_win <= win;
            if (run_nxt == RUN_LIMIT && (errClear || !stuck)) begin
                stuck    <= 1'b1;
                stuckSrc <= win;
            end else if (errClear) begin
                stuck    <= 1'b0;
                stuckSrc <= '0;
            end
        end
    end

endmodule
